// File: rtl/axi4_burst_ptgen_if.sv
// AXI4 full-master bus (address, write data, write response, read) shared by the
// pattern generator and its slave/memory.
interface axi4_burst_ptgen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_burst_ptgen.sv
// AXI4 full-master pattern generator: writes NUM_BURSTS seeded INCR bursts, then
// reads them back, flagging data, response and RLAST errors.
module axi4_burst_ptgen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int NUM_BURSTS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  INIT_AXI_TXN,
  input  logic [1:0]            MODE,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [DATA_WIDTH-1:0] SEED,
  output logic                  TXN_DONE,
  output logic                  ERROR,
  output logic                  BUSY,
  output logic [CNT_WIDTH-1:0]  ERR_COUNT,
  axi4_burst_ptgen_if.master    m_axi
);
  localparam int BW = $clog2(NUM_BURSTS) + 1;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
  localparam logic [7:0]    LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t                state, next_state;
  logic                  init_q;
  logic                  rd_en_q;
  logic                  error_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [DATA_WIDTH-1:0] seed_q, data_q;
  logic [BW-1:0]         burst_cnt;
  logic [7:0]            beat_cnt;
  logic                  start, last_beat, last_burst;

  assign start      = INIT_AXI_TXN && !init_q && (state == IDLE || state == DONE);
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_cnt == LAST_BURST);

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = (MODE == 2'd2) ? RD_ADDR : WR_ADDR;
      WR_ADDR:    if (m_axi.AWREADY) next_state = WR_DATA;
      WR_DATA:    if (m_axi.WREADY && last_beat) next_state = WR_RESP;
      WR_RESP: begin
        if (m_axi.BVALID) begin
          if (!last_burst)  next_state = WR_ADDR;
          else if (rd_en_q) next_state = RD_ADDR;
          else              next_state = DONE;
        end
      end
      RD_ADDR:    if (m_axi.ARREADY) next_state = RD_DATA;
      RD_DATA:    if (m_axi.RVALID && last_beat) next_state = last_burst ? DONE : RD_ADDR;
      default:    next_state = IDLE;
    endcase
  end

  // Address and pattern are tracked incrementally; both rewind to base/seed for the read phase.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      init_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      seed_q    <= '0;
      data_q    <= '0;
      burst_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      init_q <= INIT_AXI_TXN;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rd_en_q   <= (MODE != 2'd1);
            base_q    <= BASE_ADDR;
            addr_q    <= BASE_ADDR;
            seed_q    <= SEED;
            data_q    <= SEED;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            burst_cnt <= '0;
            beat_cnt  <= '0;
          end
        end
        WR_DATA: begin
          if (m_axi.WREADY) begin
            data_q   <= data_q + DATA_WIDTH'(1);
            beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
          end
        end
        WR_RESP: begin
          if (m_axi.BVALID) begin
            if (m_axi.BRESP != 2'b00) error_q <= 1'b1;
            if (!last_burst) begin
              burst_cnt <= burst_cnt + 1'b1;
              addr_q    <= addr_q + BURST_BYTES;
            end else begin
              burst_cnt <= '0;
              addr_q    <= base_q;
              data_q    <= seed_q;
            end
          end
        end
        RD_DATA: begin
          if (m_axi.RVALID) begin
            if (m_axi.RDATA != data_q) begin
              error_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (m_axi.RRESP != 2'b00 || m_axi.RLAST != last_beat) error_q <= 1'b1;
            data_q   <= data_q + DATA_WIDTH'(1);
            beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
            if (last_beat && !last_burst) begin
              burst_cnt <= burst_cnt + 1'b1;
              addr_q    <= addr_q + BURST_BYTES;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWLEN   = LAST_BEAT;
  assign m_axi.AWSIZE  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.AWVALID = (state == WR_ADDR);
  assign m_axi.WDATA   = data_q;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WLAST   = (state == WR_DATA) && last_beat;
  assign m_axi.WVALID  = (state == WR_DATA);
  assign m_axi.BREADY  = (state == WR_RESP);
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARLEN   = LAST_BEAT;
  assign m_axi.ARSIZE  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.ARVALID = (state == RD_ADDR);
  assign m_axi.RREADY  = (state == RD_DATA);

  assign TXN_DONE  = (state == DONE);
  assign BUSY      = (state != IDLE) && (state != DONE);
  assign ERROR     = error_q;
  assign ERR_COUNT = err_cnt_q;
endmodule

// File: tb/tb_axi4_burst_ptgen.sv
// Directed bench for axi4_burst_ptgen: a memory slave with optional stalls, BRESP
// error injection and memory corruption, checked against hand-computed values.
module tb_axi4_burst_ptgen;
  localparam int DW = 32;
  localparam int AW = 32;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        INIT_AXI_TXN;
  logic [1:0]  MODE;
  logic [31:0] BASE_ADDR;
  logic [31:0] SEED;
  logic        TXN_DONE, ERROR, BUSY;
  logic [15:0] ERR_COUNT;

  int compared   = 0;
  int mismatched = 0;

  axi4_burst_ptgen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi4_burst_ptgen #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(8), .NUM_BURSTS(4), .CNT_WIDTH(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .INIT_AXI_TXN(INIT_AXI_TXN), .MODE(MODE),
    .BASE_ADDR(BASE_ADDR), .SEED(SEED), .TXN_DONE(TXN_DONE), .ERROR(ERROR),
    .BUSY(BUSY), .ERR_COUNT(ERR_COUNT), .m_axi(bus)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] mem [256];
  logic [31:0] aw_log [8];
  logic [31:0] ar_log [8];
  int aw_count, w_count, wlast_count, wlast_bad, b_count, ar_count, r_count, stall_bad;
  int slverr_burst = -1;
  bit stall_en     = 1'b0;
  bit corrupt_en   = 1'b0;

  function automatic logic rdy();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Slave: handshakes are resolved at the falling edge from the values present at the previous rising edge.
  initial begin
    logic        p_awvalid, p_awready, p_wvalid, p_wready, p_wlast, p_bvalid, p_bready;
    logic        p_arvalid, p_arready, p_rvalid, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr, wr_addr, rd_addr;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pending, r_active;
    int          w_idx, r_idx;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    {p_awvalid, p_awready, p_wvalid, p_wready, p_wlast, p_bvalid, p_bready} = '0;
    {p_arvalid, p_arready, p_rvalid, p_rready} = '0;
    {p_awaddr, p_wdata, p_araddr, wr_addr, rd_addr} = '0;
    b_pending = 1'b0; r_active = 1'b0; w_idx = 0; r_idx = 0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.ARREADY = 1'b0;
    bus.BVALID = 1'b0; bus.BRESP = 2'b00;
    bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.ARREADY = 1'b0;
        bus.BVALID = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0;
        b_pending = 1'b0; r_active = 1'b0; w_idx = 0; r_idx = 0;
        {p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_arvalid, p_arready, p_rvalid} = '0;
      end else begin
        if (stall_en) begin
          if (p_awvalid && !p_awready && (!bus.AWVALID || bus.AWADDR !== p_awaddr)) stall_bad++;
          if (p_wvalid && !p_wready &&
              (!bus.WVALID || bus.WDATA !== p_wdata || bus.WLAST !== p_wlast)) stall_bad++;
          if (p_arvalid && !p_arready && (!bus.ARVALID || bus.ARADDR !== p_araddr)) stall_bad++;
        end
        aw_hs = p_awvalid && p_awready;
        w_hs  = p_wvalid && p_wready;
        b_hs  = p_bvalid && p_bready;
        ar_hs = p_arvalid && p_arready;
        r_hs  = p_rvalid && p_rready;
        if (aw_hs) begin
          if (aw_count < 8) aw_log[aw_count] = p_awaddr;
          aw_count++; wr_addr = p_awaddr; w_idx = 0;
        end
        if (w_hs) begin
          mem[((wr_addr >> 2) + w_idx) & 255] = p_wdata;
          if (p_wlast) wlast_count++;
          if (p_wlast !== (w_idx == 7)) wlast_bad++;
          w_count++; w_idx++;
          if (w_idx == 8) b_pending = 1'b1;
        end
        if (b_hs) begin
          b_pending = 1'b0; b_count++;
          if (corrupt_en && b_count == 4) mem[32'h44 >> 2] = 32'hDEAD;
        end
        if (ar_hs) begin
          if (ar_count < 8) ar_log[ar_count] = p_araddr;
          ar_count++; rd_addr = p_araddr; r_idx = 0; r_active = 1'b1;
        end
        if (r_hs) begin
          r_count++; r_idx++;
          if (r_idx == 8) r_active = 1'b0;
        end
        bus.AWREADY = rdy();
        bus.WREADY  = rdy();
        bus.ARREADY = rdy();
        if (!(bus.BVALID && !b_hs)) begin
          bus.BVALID = b_pending && rdy();
          bus.BRESP  = (b_count == slverr_burst) ? 2'b10 : 2'b00;
        end
        if (!(bus.RVALID && !r_hs)) begin
          bus.RVALID = r_active && rdy();
          bus.RDATA  = mem[((rd_addr >> 2) + r_idx) & 255];
          bus.RLAST  = (r_idx == 7);
          bus.RRESP  = 2'b00;
        end
      end
      p_awvalid = bus.AWVALID; p_awready = bus.AWREADY; p_awaddr = bus.AWADDR;
      p_wvalid = bus.WVALID; p_wready = bus.WREADY; p_wdata = bus.WDATA; p_wlast = bus.WLAST;
      p_bvalid = bus.BVALID; p_bready = bus.BREADY;
      p_arvalid = bus.ARVALID; p_arready = bus.ARREADY; p_araddr = bus.ARADDR;
      p_rvalid = bus.RVALID; p_rready = bus.RREADY;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] base, input logic [31:0] seed);
    MODE = mode; BASE_ADDR = base; SEED = seed;
    INIT_AXI_TXN = 1'b1;
    @(negedge ACLK);
    INIT_AXI_TXN = 1'b0;
  endtask

  task automatic clear_logs();
    aw_count = 0; w_count = 0; wlast_count = 0; wlast_bad = 0;
    b_count = 0; ar_count = 0; r_count = 0; stall_bad = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !TXN_DONE; i++) @(negedge ACLK);
    checkOutput(tag, TXN_DONE, 1'b1);
  endtask

  initial begin
    ARESET = 1'b1; INIT_AXI_TXN = 1'b0; MODE = 2'd0; BASE_ADDR = '0; SEED = '0;
    clear_logs();
    repeat (3) @(negedge ACLK);
    checkOutput("rst_valids", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}, 5'b0);
    checkOutput("rst_status", {TXN_DONE, ERROR, BUSY}, 3'b000);
    checkOutput("rst_err_count", ERR_COUNT, 16'd0);
    checkOutput("rst_addr_data", {bus.AWADDR, bus.WDATA}, 64'd0);
    checkOutput("const_aw", {bus.AWLEN, bus.AWSIZE, bus.AWBURST}, {8'd7, 3'd2, 2'b01});
    checkOutput("const_ar_strb", {bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.WSTRB}, {8'd7, 3'd2, 2'b01, 4'hF});
    ARESET = 1'b0;
    @(negedge ACLK);

    $display("[TB] mode 0 write/read, base 0x0 seed 1");
    applyStimulus(2'd0, 32'h0, 32'h1);
    checkOutput("t1_busy", {BUSY, TXN_DONE}, 2'b10);
    wait_done("t1_done", 2000);
    checkOutput("t1_aw_count", aw_count, 4);
    checkOutput("t1_aw_addrs", {aw_log[0], aw_log[1]}, {32'h00, 32'h20});
    checkOutput("t1_aw_addrs_hi", {aw_log[2], aw_log[3]}, {32'h40, 32'h60});
    checkOutput("t1_ar_last", {ar_count[7:0], ar_log[3]}, {8'd4, 32'h60});
    checkOutput("t1_w_count", {w_count[7:0], wlast_count[7:0], wlast_bad[7:0]}, {8'd32, 8'd4, 8'd0});
    checkOutput("t1_mem_first_last", {mem[0], mem[31]}, {32'h01, 32'h20});
    checkOutput("t1_status", {ERROR, BUSY, ERR_COUNT}, 18'd0);

    $display("[TB] mode 0 with word 0x44 corrupted before read-back");
    clear_logs(); corrupt_en = 1'b1;
    applyStimulus(2'd0, 32'h0, 32'h1);
    wait_done("t2_done", 2000);
    corrupt_en = 1'b0;
    checkOutput("t2_error", ERROR, 1'b1);
    checkOutput("t2_err_count", ERR_COUNT, 16'd1);
    repeat (5) @(negedge ACLK);
    checkOutput("t2_hold_in_done", {TXN_DONE, ERR_COUNT}, {1'b1, 16'd1});

    $display("[TB] mode 1 write only, SLVERR on second burst");
    clear_logs(); slverr_burst = 1;
    applyStimulus(2'd1, 32'h100, 32'h1000);
    checkOutput("t3_start_clears", {TXN_DONE, ERROR, ERR_COUNT}, 18'd0);
    wait_done("t3_done", 2000);
    slverr_burst = -1;
    checkOutput("t3_error", {ERROR, ERR_COUNT}, {1'b1, 16'd0});
    checkOutput("t3_counts", {aw_count[7:0], b_count[7:0], ar_count[7:0]}, {8'd4, 8'd4, 8'd0});
    checkOutput("t3_addrs", {aw_log[1], aw_log[3]}, {32'h120, 32'h160});
    checkOutput("t3_mem", mem[64 + 31], 32'h101F);

    $display("[TB] mode 0 with random stalls, wrapping seed");
    clear_logs(); stall_en = 1'b1;
    applyStimulus(2'd0, 32'h0, 32'hFFFF_FFF0);
    wait_done("t4_done", 4000);
    stall_en = 1'b0;
    checkOutput("t4_stall_stable", stall_bad, 0);
    checkOutput("t4_w_beats", {w_count[7:0], wlast_count[7:0], wlast_bad[7:0]}, {8'd32, 8'd4, 8'd0});
    checkOutput("t4_r_beats", r_count, 32);
    checkOutput("t4_mem_wrap", {mem[15], mem[16], mem[31]}, {32'hFFFF_FFFF, 32'h0, 32'hF});
    checkOutput("t4_status", {ERROR, ERR_COUNT}, 17'd0);

    $display("[TB] second INIT while busy is ignored");
    clear_logs();
    applyStimulus(2'd3, 32'h0, 32'h5);
    repeat (4) @(negedge ACLK);
    checkOutput("t5_busy_before_reinit", BUSY, 1'b1);
    INIT_AXI_TXN = 1'b1;
    @(negedge ACLK);
    INIT_AXI_TXN = 1'b0;
    wait_done("t5_done", 2000);
    repeat (20) @(negedge ACLK);
    checkOutput("t5_single_pass", {aw_count[7:0], ar_count[7:0]}, {8'd4, 8'd4});
    checkOutput("t5_done_sticky", {TXN_DONE, BUSY, ERROR}, 3'b100);
    checkOutput("t5_mem", mem[9], 32'hE);
    applyStimulus(2'd1, 32'h0, 32'h5);
    checkOutput("t5_restart_clears_done", {TXN_DONE, BUSY}, 2'b01);
    wait_done("t5_done2", 2000);

    $display("[TB] reset during third write burst");
    clear_logs(); slverr_burst = 1;
    applyStimulus(2'd0, 32'h0, 32'h7);
    for (int i = 0; i < 500 && aw_count < 3; i++) @(negedge ACLK);
    checkOutput("t6_reached_burst2", aw_count >= 3, 1'b1);
    @(negedge ACLK);
    checkOutput("t6_before_reset", {bus.WVALID, BUSY, ERROR}, 3'b111);
    ARESET = 1'b1;
    @(negedge ACLK);
    checkOutput("t6_reset_valids", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}, 5'b0);
    checkOutput("t6_reset_status", {BUSY, TXN_DONE, ERROR, ERR_COUNT}, 19'd0);
    @(negedge ACLK);
    ARESET = 1'b0; slverr_burst = -1;
    repeat (2) @(negedge ACLK);
    clear_logs();
    applyStimulus(2'd1, 32'h200, 32'h0);
    wait_done("t6_done", 2000);
    checkOutput("t6_restart_addr", {aw_log[0], aw_log[3]}, {32'h200, 32'h260});
    checkOutput("t6_restart_mem", {mem[128 + 9], mem[128 + 31]}, {32'h9, 32'h1F});
    checkOutput("t6_restart_status", {aw_count[7:0], ERROR}, {8'd4, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
